// File: rtl/des_block_loader.sv
// Byte-serial loader feeding the DES stage with KEY and PLAIN_TEXT.
// Packs bytes into 64-bit words, stalls byte 7 while a block is pending.
module des_block_loader #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_is_key,
  input  logic             in_abort,
  output logic [63:0]      PLAIN_TEXT,
  output logic [63:0]      KEY,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             key_loaded,
  output logic             err_nokey,
  output logic [CNT_W-1:0] blk_cnt
);

  logic [2:0]  byte_cnt;
  logic [63:0] shift_q;
  logic [63:0] shift_d;
  logic        word_key;
  logic        cur_key;
  logic        last;
  logic        accept;
  logic        handshake;
  logic        done_key;
  logic        done_plain;

  assign last      = byte_cnt == 3'd7;
  assign handshake = out_valid && out_ready;
  assign in_ready  = !in_abort &&
                     (!last || !out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // Word type comes from byte 0 only; later bytes use the latched copy.
  assign cur_key    = (byte_cnt == 3'd0) ? in_is_key : word_key;
  assign done_key   = accept && last && cur_key;
  assign done_plain = accept && last && !cur_key;

  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST) begin
      shift_d = {shift_q[55:0], in_data};
    end else begin
      shift_d[{byte_cnt, 3'b000} +: 8] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 3'd0;
      shift_q    <= 64'd0;
      word_key   <= 1'b0;
      PLAIN_TEXT <= 64'd0;
      KEY        <= 64'd0;
      out_valid  <= 1'b0;
      key_loaded <= 1'b0;
      err_nokey  <= 1'b0;
      blk_cnt    <= '0;
    end else begin
      err_nokey <= 1'b0;
      if (in_abort) begin
        byte_cnt <= 3'd0;
        shift_q  <= 64'd0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 3'd1;
        shift_q  <= shift_d;
        if (byte_cnt == 3'd0) begin
          word_key <= in_is_key;
        end
      end
      if (done_key) begin
        KEY        <= shift_d;
        key_loaded <= 1'b1;
      end
      if (done_plain) begin
        if (key_loaded) begin
          PLAIN_TEXT <= shift_d;
        end else begin
          err_nokey <= 1'b1;
        end
      end
      // A new block landing on the handshake edge keeps out_valid high.
      if (done_plain && key_loaded) begin
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (handshake) begin
        blk_cnt <= blk_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_des_block_loader.sv
// Bench for des_block_loader: MSB-first and LSB-first builds, CNT_W=4,
// checked each cycle against a byte-list model plus literal expectations.
module tb_des_block_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_is_key;
  logic        in_abort;
  logic        out_ready;

  logic        a_rdy, b_rdy;
  logic [63:0] a_pt, b_pt, a_key, b_key;
  logic        a_ov, b_ov, a_kl, b_kl, a_err, b_err;
  logic [3:0]  a_blk, b_blk;

  int checks = 0;
  int failures = 0;

  des_block_loader #(.MSB_FIRST(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_rdy),
    .in_data(in_data), .in_is_key(in_is_key),
    .in_abort(in_abort),
    .PLAIN_TEXT(a_pt), .KEY(a_key),
    .out_valid(a_ov), .out_ready(out_ready),
    .key_loaded(a_kl), .err_nokey(a_err),
    .blk_cnt(a_blk)
  );

  des_block_loader #(.MSB_FIRST(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_rdy),
    .in_data(in_data), .in_is_key(in_is_key),
    .in_abort(in_abort),
    .PLAIN_TEXT(b_pt), .KEY(b_key),
    .out_valid(b_ov), .out_ready(out_ready),
    .key_loaded(b_kl), .err_nokey(b_err),
    .blk_cnt(b_blk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: list of bytes of the current word, word assembled at completion.
  logic [7:0]  m_bytes [8];
  int          m_idx;
  logic        m_typ;
  logic [63:0] m_pt_a, m_pt_b, m_key_a, m_key_b;
  logic        m_ov, m_kl, m_err;
  int          m_blk;

  function automatic logic model_rdy();
    return !in_abort && (m_idx != 7 || !m_ov || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0]  nb [8];
    logic [63:0] wa, wb;
    logic        typ, acc, hs;
    if (!rst_n) begin
      m_idx <= 0; m_typ <= 1'b0;
      m_pt_a <= '0; m_pt_b <= '0;
      m_key_a <= '0; m_key_b <= '0;
      m_ov <= 1'b0; m_kl <= 1'b0;
      m_err <= 1'b0; m_blk <= 0;
      for (int i = 0; i < 8; i++) m_bytes[i] <= 8'h00;
    end else begin
      acc = in_valid && model_rdy();
      hs  = m_ov && out_ready;
      m_err <= 1'b0;
      if (hs) m_blk <= (m_blk + 1) % 16;
      if (hs) m_ov <= 1'b0;
      if (in_abort) begin
        m_idx <= 0;
      end else if (acc) begin
        nb = m_bytes;
        nb[m_idx] = in_data;
        m_bytes <= nb;
        typ = (m_idx == 0) ? in_is_key : m_typ;
        m_typ <= typ;
        m_idx <= (m_idx + 1) % 8;
        if (m_idx == 7) begin
          for (int i = 0; i < 8; i++) begin
            wa[63-8*i -: 8] = nb[i];
            wb[8*i +: 8]    = nb[i];
          end
          if (typ) begin
            m_key_a <= wa; m_key_b <= wb; m_kl <= 1'b1;
          end else if (m_kl) begin
            m_pt_a <= wa; m_pt_b <= wb; m_ov <= 1'b1;
          end else begin
            m_err <= 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_in_ready", 64'(a_rdy), 64'(model_rdy()));
      chk("b_in_ready", 64'(b_rdy), 64'(model_rdy()));
      chk("a_plain", a_pt, m_pt_a);
      chk("b_plain", b_pt, m_pt_b);
      chk("a_key", a_key, m_key_a);
      chk("b_key", b_key, m_key_b);
      chk("a_out_valid", 64'(a_ov), 64'(m_ov));
      chk("b_out_valid", 64'(b_ov), 64'(m_ov));
      chk("a_key_loaded", 64'(a_kl), 64'(m_kl));
      chk("b_key_loaded", 64'(b_kl), 64'(m_kl));
      chk("a_err_nokey", 64'(a_err), 64'(m_err));
      chk("b_err_nokey", 64'(b_err), 64'(m_err));
      chk("a_blk_cnt", 64'(a_blk), 64'(m_blk));
      chk("b_blk_cnt", 64'(b_blk), 64'(m_blk));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic k);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    in_valid = 1'b1; in_data = d; in_is_key = k;
    while (!got && n < 20) begin
      @(negedge clk);
      got = a_rdy;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL send_byte actual=stalled required=accepted");
    end
  endtask

  // Byte 0 carries the type; later bytes carry the opposite to prove it is ignored.
  task automatic send_bytes(input logic [63:0] w, input logic k,
                            input int first, input int cnt);
    for (int i = first; i < first + cnt; i++)
      send_byte(w[63-8*i -: 8], (i == 0) ? k : !k);
  endtask

  task automatic send_word(input logic [63:0] w, input logic k);
    send_bytes(w, k, 0, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_is_key = 1'b0; in_abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(a_rdy), 64'd1);
    chk("rst_key", a_key, 64'd0);
    chk("rst_out_valid", 64'(a_ov), 64'd0);
    step();

    // plaintext with no key loaded
    send_word(64'h0123456789ABCDEF, 1'b0);
    chk("nokey_err", 64'(a_err), 64'd1);
    chk("nokey_ov", 64'(a_ov), 64'd0);
    chk("nokey_pt", a_pt, 64'd0);
    step();
    chk("nokey_err_pulse", 64'(a_err), 64'd0);

    send_word(64'h133457799BBCDFF1, 1'b1);
    chk("key_a", a_key, 64'h133457799BBCDFF1);
    chk("key_b", b_key, 64'hF1DFBC9B79573413);
    chk("key_loaded", 64'(a_kl), 64'd1);
    chk("key_ov", 64'(a_ov), 64'd0);

    send_word(64'h0123456789ABCDEF, 1'b0);
    chk("pt_a", a_pt, 64'h0123456789ABCDEF);
    chk("pt_b", b_pt, 64'hEFCDAB8967452301);
    chk("pt_ov", 64'(a_ov), 64'd1);

    // second plaintext stalls at byte 7 while the first is pending
    send_bytes(64'h1122334455667788, 1'b0, 0, 7);
    in_valid = 1'b1; in_data = 8'h88; in_is_key = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_rdy", 64'(a_rdy), 64'd0);
      chk("stall_pt", a_pt, 64'h0123456789ABCDEF);
    end
    out_ready = 1'b1;
    step();
    chk("b2b_pt", a_pt, 64'h1122334455667788);
    chk("b2b_ov", 64'(a_ov), 64'd1);
    chk("b2b_blk", 64'(a_blk), 64'd1);
    in_valid = 1'b0; out_ready = 1'b0;

    // key word while a block is pending
    send_bytes(64'h0F1E2D3C4B5A6978, 1'b1, 0, 7);
    in_valid = 1'b1; in_data = 8'h78; in_is_key = 1'b0;
    repeat (2) step();
    chk("kstall_key", a_key, 64'h133457799BBCDFF1);
    out_ready = 1'b1;
    step();
    chk("kswap_key", a_key, 64'h0F1E2D3C4B5A6978);
    chk("kswap_ov", 64'(a_ov), 64'd0);
    chk("kswap_pt", a_pt, 64'h1122334455667788);
    chk("kswap_blk", 64'(a_blk), 64'd2);
    in_valid = 1'b0; out_ready = 1'b0;

    // abort after five bytes
    send_bytes(64'hF0F1F2F3F4F5F6F7, 1'b0, 0, 5);
    in_abort = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    #1 chk("abort_rdy", 64'(a_rdy), 64'd0);
    step();
    in_abort = 1'b0; in_valid = 1'b0;
    send_word(64'hAAAAAAAAAAAAAAAA, 1'b0);
    chk("abort_pt_a", a_pt, 64'hAAAAAAAAAAAAAAAA);
    chk("abort_pt_b", b_pt, 64'hAAAAAAAAAAAAAAAA);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("abort_blk", 64'(a_blk), 64'd3);

    // 14 more handshakes: 17 total wraps a 4-bit counter to 1
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++)
      send_word(64'h1000000000000000 + 64'(i), 1'b0);
    step();
    out_ready = 1'b0;
    chk("wrap_blk", 64'(a_blk), 64'd1);
    chk("wrap_ov", 64'(a_ov), 64'd0);

    send_word(64'h0102030405060708, 1'b0);
    chk("order_a", a_pt, 64'h0102030405060708);
    chk("order_b", b_pt, 64'h0807060504030201);

    // asynchronous reset mid-word
    send_bytes(64'h2233445566778899, 1'b1, 0, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pt", a_pt, 64'd0);
    chk("arst_key", a_key, 64'd0);
    chk("arst_ov", 64'(a_ov), 64'd0);
    chk("arst_kl", 64'(a_kl), 64'd0);
    chk("arst_blk", 64'(a_blk), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
